// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the slave front ends: HTRANS/HSIZE/HRESP
// codes, the RAM controller state encoding and the captured-transfer record.
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_ERR1,
        ST_ERR2
    } ctrl_state_t;

    // Address-phase information carried into the data phase.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic        legal;
    } xfer_t;

    // A real transfer is requested only for NONSEQ/SEQ with the slave selected;
    // IDLE and BUSY never start a data phase.
    function automatic logic is_xfer(input logic hsel, input logic [1:0] htrans);
        return hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/ahb_ram_slave_ctrl_if.sv
// ----------------------------------------------------------------------------
// ahb_ram_slave_ctrl_if
// AHB-Lite slave-side bus bundle.
//   master modport: drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA,
//                   receives HRDATA/HREADYOUT/HRESP.
//   slave  modport: the mirror image.
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS is
// NONSEQ/SEQ at a rising edge; the data phase completes at the first rising
// edge where HREADYOUT is high, with HRESP/HRDATA valid in that cycle.
// ----------------------------------------------------------------------------
interface ahb_ram_slave_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_xfer_check.sv
// ----------------------------------------------------------------------------
// ahb_xfer_check
// Combinational legality check for a word-only AHB slave.
//   haddr_i : address-phase HADDR
//   hsize_i : address-phase HSIZE
//   legal_o : 1 when the transfer is a word, word-aligned and inside MEM_BYTES
// ----------------------------------------------------------------------------
module ahb_xfer_check
    import ahb_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic [31:0] haddr_i,
    input  logic [2:0]  hsize_i,
    output logic        legal_o
);

    assign legal_o = (hsize_i == HSIZE_WORD) &&
                     (haddr_i[1:0] == 2'b00) &&
                     (haddr_i < 32'(MEM_BYTES));

endmodule

// File: rtl/ahb_ram_slave_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_ram_slave_ctrl
// AHB-Lite slave front end for the registered-read Data_Memory.
//   clk, reset_n    : clock, asynchronous active-low reset
//   ahb (slave)     : AHB-Lite bus bundle
//   mem_sel         : Data_Memory select (HSEL2)
//   mem_write/read  : memory strobes, never both high
//   address_ram     : captured byte address of the current data phase
//   write_data      : memory write data (HWDATA during the write data phase)
//   read_data       : registered memory read data
//   state_dbg_o     : current controller state
// Writes complete with zero wait; reads hold HREADYOUT low for RD_WAIT
// cycles (1..4) and strobe the memory in the last of them; illegal transfers
// get the two-cycle ERROR response.
// ----------------------------------------------------------------------------
module ahb_ram_slave_ctrl
    import ahb_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int RD_WAIT   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ahb_ram_slave_ctrl_if.slave  ahb,
    output logic                 mem_sel,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [31:0]          address_ram,
    output logic [31:0]          write_data,
    input  logic [31:0]          read_data,
    output ctrl_state_t          state_dbg_o
);

    localparam logic [2:0] RD_LAST = 3'(RD_WAIT - 1);

    ctrl_state_t state_q, state_d;
    xfer_t       xfer_q, xfer_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        legal;
    logic        accept_state;

    ahb_xfer_check #(.MEM_BYTES(MEM_BYTES)) u_check (
        .haddr_i (ahb.HADDR),
        .hsize_i (ahb.HSIZE),
        .legal_o (legal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            xfer_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        xfer_d        = xfer_q;
        cnt_d         = cnt_q;
        accept_state  = 1'b0;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = HRESP_OKAY;
        ahb.HRDATA    = '0;
        mem_sel       = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        address_ram   = '0;
        write_data    = '0;

        case (state_q)
            ST_IDLE: accept_state = 1'b1;
            ST_WR: begin
                accept_state = 1'b1;
                // The captured flags re-qualify the strobe so an illegal
                // transfer can never reach the memory.
                if (xfer_q.write && xfer_q.legal) begin
                    mem_sel     = 1'b1;
                    mem_write   = 1'b1;
                    address_ram = xfer_q.addr;
                    write_data  = ahb.HWDATA;
                end
            end
            ST_RD_WAIT: begin
                ahb.HREADYOUT = 1'b0;
                if (cnt_q == RD_LAST) begin
                    // Memory registers read_data at the edge closing this cycle.
                    if (!xfer_q.write && xfer_q.legal) begin
                        mem_sel     = 1'b1;
                        mem_read    = 1'b1;
                        address_ram = xfer_q.addr;
                    end
                    cnt_d   = '0;
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RD_DATA: begin
                accept_state = 1'b1;
                ahb.HRDATA   = read_data;
            end
            ST_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = HRESP_ERROR;
                state_d       = ST_ERR2;
            end
            ST_ERR2: begin
                accept_state = 1'b1;
                ahb.HRESP    = HRESP_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        // With HREADY low another slave is stalling the bus: hold everything.
        if (accept_state && ahb.HREADY) begin
            if (is_xfer(ahb.HSEL, ahb.HTRANS)) begin
                xfer_d = '{addr: ahb.HADDR, write: ahb.HWRITE, legal: legal};
                cnt_d  = '0;
                if (!legal)          state_d = ST_ERR1;
                else if (ahb.HWRITE) state_d = ST_WR;
                else                 state_d = ST_RD_WAIT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ahb_ram_slave_ctrl.sv
module tb_ahb_ram_slave_ctrl;
    import ahb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic stall = 1'b0;
    logic load_mem = 1'b1;

    // ---------------- DUT with RD_WAIT=1 ----------------
    ahb_ram_slave_ctrl_if bus1();
    assign bus1.HREADY = bus1.HREADYOUT & ~stall;
    logic        m1_sel, m1_write, m1_read;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    ctrl_state_t dbg1;

    ahb_ram_slave_ctrl #(.MEM_BYTES(1024), .RD_WAIT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ahb(bus1),
        .mem_sel(m1_sel), .mem_write(m1_write), .mem_read(m1_read),
        .address_ram(m1_addr), .write_data(m1_wdata), .read_data(m1_rdata),
        .state_dbg_o(dbg1)
    );

    // ---------------- DUT with RD_WAIT=3 ----------------
    ahb_ram_slave_ctrl_if bus3();
    assign bus3.HREADY = bus3.HREADYOUT;
    logic        m3_sel, m3_write, m3_read;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    ctrl_state_t dbg3;

    ahb_ram_slave_ctrl #(.MEM_BYTES(1024), .RD_WAIT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .ahb(bus3),
        .mem_sel(m3_sel), .mem_write(m3_write), .mem_read(m3_read),
        .address_ram(m3_addr), .write_data(m3_wdata), .read_data(m3_rdata),
        .state_dbg_o(dbg3)
    );

    // ---------------- Data_Memory models (registered read) ----------------
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h1122_3344;
            1:       return 32'h5566_7788;
            4:       return 32'h1234_5678;
            17:      return 32'hA5A5_A5A5;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
            m1_rdata <= '0;
        end else begin
            if (m1_sel && m1_write) mem1[m1_addr[9:2]] <= m1_wdata;
            if (m1_sel && m1_read)  m1_rdata <= mem1[m1_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
            m3_rdata <= '0;
        end else begin
            if (m3_sel && m3_write) mem3[m3_addr[9:2]] <= m3_wdata;
            if (m3_sel && m3_read)  m3_rdata <= mem3[m3_addr[9:2]];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive1(input logic sel, input logic [1:0] trans, input logic wr,
                          input logic [2:0] size, input logic [31:0] addr);
        bus1.HSEL   = sel;
        bus1.HTRANS = trans;
        bus1.HWRITE = wr;
        bus1.HSIZE  = size;
        bus1.HADDR  = addr;
    endtask

    task automatic idle1();
        drive1(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        load_mem = 1'b1;
        cycle();
        cycle();
        settle();
        if (bus1.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b expected 1", bus1.HREADYOUT); end
        checks++;
        if (bus1.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b expected 0", bus1.HRESP); end
        checks++;
        if (bus1.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 0", bus1.HRDATA); end
        checks++;
        if ({m1_sel, m1_write, m1_read} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {m1_sel, m1_write, m1_read}); end
        checks++;
        if ({m1_addr, m1_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h expected 0", {m1_addr, m1_wdata}); end
        checks++;
        if (dbg1 !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg1, ST_IDLE); end
        checks++;
        load_mem = 1'b0;
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_read();
        int waits;
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04);
        cycle();
        idle1();
        settle();
        waits = 0;
        while (bus1.HREADYOUT === 1'b0 && waits < 8) begin
            waits++;
            if ({m1_sel, m1_read, m1_write} !== 3'b110 || m1_addr !== 32'h04) begin
                errors++; $display("FAIL read_strobe: got sel/rd/wr=%b addr=%h expected 110 addr=00000004", {m1_sel, m1_read, m1_write}, m1_addr);
            end
            checks++;
            cycle();
            settle();
        end
        if (waits !== 1) begin errors++; $display("FAIL read_waits: got %0d expected 1", waits); end
        checks++;
        if (bus1.HRDATA !== 32'h5566_7788 || bus1.HRESP !== 1'b0) begin
            errors++; $display("FAIL read_data: got %h resp %b expected 55667788 resp 0", bus1.HRDATA, bus1.HRESP);
        end
        checks++;
        if (m1_read !== 1'b0) begin errors++; $display("FAIL read_data_strobe: got %b expected 0", m1_read); end
        checks++;
        cycle();
        settle();
        if (bus1.HRDATA !== 32'h0 || dbg1 !== ST_IDLE) begin
            errors++; $display("FAIL read_return_idle: got hrdata %h state %0d expected 0 state %0d", bus1.HRDATA, dbg1, ST_IDLE);
        end
        checks++;
    endtask

    task automatic test_write_read_pipelined();
        drive1(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
        cycle();
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
        bus1.HWDATA = 32'hDEAD_BEEF;
        settle();
        if (bus1.HREADYOUT !== 1'b1) begin errors++; $display("FAIL wr_zero_wait: got %b expected 1", bus1.HREADYOUT); end
        checks++;
        if ({m1_sel, m1_write, m1_read} !== 3'b110 || m1_addr !== 32'h40 || m1_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_strobe: got sel/wr/rd=%b addr=%h data=%h expected 110 00000040 deadbeef", {m1_sel, m1_write, m1_read}, m1_addr, m1_wdata);
        end
        checks++;
        cycle();
        idle1();
        bus1.HWDATA = 32'h0;
        settle();
        if (bus1.HREADYOUT !== 1'b0 || {m1_sel, m1_read, m1_write} !== 3'b110 || m1_addr !== 32'h40) begin
            errors++; $display("FAIL raw_read_wait: got ready %b sel/rd/wr=%b addr=%h expected 0 110 00000040", bus1.HREADYOUT, {m1_sel, m1_read, m1_write}, m1_addr);
        end
        checks++;
        cycle();
        settle();
        if (bus1.HREADYOUT !== 1'b1 || bus1.HRDATA !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL raw_read_data: got ready %b data %h expected 1 deadbeef", bus1.HREADYOUT, bus1.HRDATA);
        end
        checks++;
        cycle();
    endtask

    task automatic test_illegal();
        logic        wr_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  sz_t [4] = '{3'b000, HSIZE_WORD, HSIZE_WORD, HSIZE_WORD};
        logic [31:0] ad_t [4] = '{32'h44, 32'h41, 32'h400, 32'h41};
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, HTRANS_NONSEQ, wr_t[i], sz_t[i], ad_t[i]);
            cycle();
            idle1();
            bus1.HWDATA = 32'hBAD0_BAD0;
            settle();
            if ({bus1.HREADYOUT, bus1.HRESP} !== 2'b01 || {m1_sel, m1_write, m1_read} !== 3'b000) begin
                errors++; $display("FAIL err1_%0d: got ready/resp %b strobes %b expected 01 000", i, {bus1.HREADYOUT, bus1.HRESP}, {m1_sel, m1_write, m1_read});
            end
            checks++;
            cycle();
            settle();
            if ({bus1.HREADYOUT, bus1.HRESP} !== 2'b11 || {m1_sel, m1_write, m1_read} !== 3'b000) begin
                errors++; $display("FAIL err2_%0d: got ready/resp %b strobes %b expected 11 000", i, {bus1.HREADYOUT, bus1.HRESP}, {m1_sel, m1_write, m1_read});
            end
            checks++;
            cycle();
            settle();
            if (bus1.HRESP !== 1'b0 || dbg1 !== ST_IDLE) begin
                errors++; $display("FAIL err_done_%0d: got resp %b state %0d expected 0 state %0d", i, bus1.HRESP, dbg1, ST_IDLE);
            end
            checks++;
            cycle();
        end
        bus1.HWDATA = 32'h0;
        if (mem1[0] !== 32'h1122_3344 || mem1[16] !== 32'hDEAD_BEEF || mem1[17] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL err_mem_intact: got %h %h %h expected 11223344 deadbeef a5a5a5a5", mem1[0], mem1[16], mem1[17]);
        end
        checks++;
    endtask

    task automatic test_idle_busy();
        logic       sel_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] tr_t  [4] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ};
        for (int i = 0; i < 4; i++) begin
            drive1(sel_t[i], tr_t[i], 1'b1, HSIZE_WORD, 32'h08);
            cycle();
            settle();
            if ({bus1.HREADYOUT, bus1.HRESP} !== 2'b10 || {m1_sel, m1_write, m1_read} !== 3'b000 || dbg1 !== ST_IDLE) begin
                errors++; $display("FAIL noxfer_%0d: got ready/resp %b strobes %b state %0d expected 10 000 %0d", i, {bus1.HREADYOUT, bus1.HRESP}, {m1_sel, m1_write, m1_read}, dbg1, ST_IDLE);
            end
            checks++;
        end
        // BUSY in the read data phase ends the burst without a new transfer.
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04);
        cycle();
        drive1(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h08);
        cycle();
        settle();
        if (bus1.HRDATA !== 32'h5566_7788) begin errors++; $display("FAIL busy_read_data: got %h expected 55667788", bus1.HRDATA); end
        checks++;
        cycle();
        settle();
        if (dbg1 !== ST_IDLE || {m1_sel, m1_write, m1_read} !== 3'b000 || bus1.HREADYOUT !== 1'b1) begin
            errors++; $display("FAIL busy_after_read: got state %0d strobes %b ready %b expected %0d 000 1", dbg1, {m1_sel, m1_write, m1_read}, bus1.HREADYOUT, ST_IDLE);
        end
        checks++;
        idle1();
        cycle();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h04);
        cycle();
        settle();
        if (dbg1 !== ST_IDLE || m1_read !== 1'b0) begin
            errors++; $display("FAIL stall_hold: got state %0d read %b expected %0d 0", dbg1, m1_read, ST_IDLE);
        end
        checks++;
        stall = 1'b0;
        cycle();
        idle1();
        settle();
        if (dbg1 !== ST_RD_WAIT) begin errors++; $display("FAIL stall_release: got state %0d expected %0d", dbg1, ST_RD_WAIT); end
        checks++;
        cycle();
        settle();
        if (bus1.HRDATA !== 32'h5566_7788) begin errors++; $display("FAIL stall_read_data: got %h expected 55667788", bus1.HRDATA); end
        checks++;
        cycle();
    endtask

    task automatic test_reset_mid_read();
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        cycle();
        idle1();
        if (bus1.HREADYOUT !== 1'b0 || m1_read !== 1'b1) begin
            errors++; $display("FAIL rst_pre_wait: got ready %b read %b expected 0 1", bus1.HREADYOUT, m1_read);
        end
        checks++;
        #1 reset_n = 1'b0;
        #1;
        if (bus1.HREADYOUT !== 1'b1 || bus1.HRDATA !== 32'h0 || {m1_sel, m1_write, m1_read} !== 3'b000 || m1_addr !== 32'h0 || dbg1 !== ST_IDLE) begin
            errors++; $display("FAIL rst_async: got ready %b data %h strobes %b addr %h state %0d expected 1 0 000 0 %0d", bus1.HREADYOUT, bus1.HRDATA, {m1_sel, m1_write, m1_read}, m1_addr, dbg1, ST_IDLE);
        end
        checks++;
        cycle();
        settle();
        reset_n = 1'b1;
        cycle();
        drive1(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
        cycle();
        idle1();
        settle();
        if (bus1.HREADYOUT !== 1'b0) begin errors++; $display("FAIL rst_after_wait: got %b expected 0", bus1.HREADYOUT); end
        checks++;
        cycle();
        settle();
        if (bus1.HREADYOUT !== 1'b1 || bus1.HRDATA !== 32'h1234_5678) begin
            errors++; $display("FAIL rst_after_data: got ready %b data %h expected 1 12345678", bus1.HREADYOUT, bus1.HRDATA);
        end
        checks++;
        cycle();
    endtask

    task automatic test_rd_wait3();
        int waits;
        bus3.HSEL = 1'b1; bus3.HTRANS = HTRANS_NONSEQ; bus3.HWRITE = 1'b0;
        bus3.HSIZE = HSIZE_WORD; bus3.HADDR = 32'h10;
        cycle();
        bus3.HSEL = 1'b0; bus3.HTRANS = HTRANS_IDLE; bus3.HADDR = 32'h0;
        settle();
        waits = 0;
        while (bus3.HREADYOUT === 1'b0 && waits < 10) begin
            waits++;
            if (m3_read !== (waits == 3) || m3_write !== 1'b0) begin
                errors++; $display("FAIL w3_strobe_%0d: got rd %b wr %b expected %b 0", waits, m3_read, m3_write, (waits == 3));
            end
            checks++;
            cycle();
            settle();
        end
        if (waits !== 3) begin errors++; $display("FAIL w3_waits: got %0d expected 3", waits); end
        checks++;
        if (bus3.HRDATA !== 32'h1234_5678) begin errors++; $display("FAIL w3_data: got %h expected 12345678", bus3.HRDATA); end
        checks++;
        cycle();
    endtask

    initial begin
        idle1();
        bus1.HWDATA = 32'h0;
        bus3.HSEL = 1'b0; bus3.HTRANS = HTRANS_IDLE; bus3.HWRITE = 1'b0;
        bus3.HSIZE = HSIZE_WORD; bus3.HADDR = 32'h0; bus3.HWDATA = 32'h0;
        test_reset();
        test_single_read();
        test_write_read_pipelined();
        test_illegal();
        test_idle_busy();
        test_stall();
        test_reset_mid_read();
        test_rd_wait3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
